// File: rtl/divider_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package divider_pkg;
  localparam int DIV_WIDTH = 16;
  localparam int DIV_ITER  = 16;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/trial_subtractor.sv
// Combinational A - B used by the restoring divider; the MSB of the
// difference is the borrow and doubles as the negative flag.
module trial_subtractor #(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         negative
);
  assign diff     = a + ~b + {{(W-1){1'b0}}, 1'b1};
  assign negative = diff[W-1];
endmodule

// File: rtl/sequential_divider.sv
// 16-bit unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake toward the control unit.
module sequential_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CNT_W = $clog2(DIV_ITER);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITER - 1);

  state_t           state, state_nxt;
  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] dvd_sh;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH:0]   prem;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   trial_a, trial_b, trial_d, prem_nxt;
  logic             trial_neg;
  logic [WIDTH-1:0] quo_nxt;
  logic             unused_prem_msb;

  assign accept    = start && (state != RUN);
  assign last_iter = (cnt == LAST_ITER);

  // The stored remainder is always below the divisor, so its MSB never
  // reaches the next trial.
  assign trial_a         = {prem[WIDTH-1:0], dvd_sh[WIDTH-1]};
  assign trial_b         = {1'b0, dvs_r};
  assign unused_prem_msb = prem[WIDTH];

  trial_subtractor #(.W(WIDTH + 1)) u_trial (
    .a        (trial_a),
    .b        (trial_b),
    .diff     (trial_d),
    .negative (trial_neg)
  );

  assign prem_nxt = trial_neg ? trial_a : trial_d;
  assign quo_nxt  = {quo_sh[WIDTH-2:0], ~trial_neg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = (divisor == '0) ? DONE : RUN;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd_sh      <= '0;
      dvs_r       <= '0;
      quo_sh      <= '0;
      prem        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvd_sh <= dividend;
      dvs_r  <= divisor;
      quo_sh <= '0;
      prem   <= '0;
      cnt    <= '0;
      if (divisor == '0) begin
        quotient    <= WIDTH'(DIV_ZERO_QUO);
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      dvd_sh <= {dvd_sh[WIDTH-2:0], 1'b0};
      prem   <= prem_nxt;
      quo_sh <= quo_nxt;
      cnt    <= cnt + 1'b1;
      if (last_iter) begin
        quotient    <= quo_nxt;
        remainder   <= prem_nxt[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end
endmodule
